// File: rtl/regfile_mp_sb_pkg.sv
// Shared types and defaults for the decode-stage register file and its write scoreboard.
package regfile_mp_sb_pkg;
  localparam int NREG_DEFAULT = 32;
  typedef logic [31:0]                       word_t;
  typedef logic [$clog2(NREG_DEFAULT)-1:0]   regidx_t;
  localparam regidx_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register pending-write counters: issue reserves, releasing writebacks retire, flush clears.
module rf_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int NREG   = NREG_DEFAULT,
  parameter int PEND_W = 2,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREAD*AW-1:0]  ra_i,
  input  logic [NWRITE-1:0]    we_i,
  input  logic [NWRITE*AW-1:0] wa_i,
  input  logic [NWRITE-1:0]    wb_release_i,
  input  logic                 iss_valid_i,
  input  logic [AW-1:0]        iss_addr_i,
  input  logic                 flush_i,
  output logic [NREAD-1:0]     rd_ready_o,
  output logic                 iss_stall_o,
  output logic                 err_underflow_o
);
  localparam int SW = PEND_W + NWRITE;
  typedef logic [PEND_W-1:0] pend_t;

  pend_t          cnt_q [NREG];
  pend_t          cnt_d [NREG];
  logic           uf_q, uf_d;
  logic [SW-1:0]  sum_v, dec_v;

  // Stall looks only at the registered count, ignoring any same-cycle release.
  assign iss_stall_o     = iss_valid_i && (cnt_q[iss_addr_i] == pend_t'('1));
  assign err_underflow_o = uf_q;

  always_comb begin
    uf_d  = 1'b0;
    sum_v = '0;
    dec_v = '0;
    for (int k = 0; k < NREG; k++) begin
      cnt_d[k] = '0;
      if (k != 0 && !flush_i) begin
        sum_v = SW'(cnt_q[k]) + SW'(iss_valid_i && !iss_stall_o && (iss_addr_i == AW'(k)));
        dec_v = '0;
        for (int i = 0; i < NWRITE; i++) begin
          if (we_i[i] && wb_release_i[i] && (wa_i[i*AW +: AW] == AW'(k)))
            dec_v = dec_v + SW'(1);
        end
        if (dec_v > sum_v) uf_d = 1'b1;
        else               cnt_d[k] = pend_t'(sum_v - dec_v);
      end
    end
  end

  for (genvar gj = 0; gj < NREAD; gj++) begin : g_ready
    logic [AW-1:0] ra_j;
    assign ra_j           = ra_i[gj*AW +: AW];
    assign rd_ready_o[gj] = reset_i || (cnt_d[ra_j] == '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NREG; k++) cnt_q[k] <= '0;
      uf_q <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) cnt_q[k] <= cnt_d[k];
      if (uf_d) uf_q <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write bypass; r0 is hardwired to zero.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int DATA_W = $bits(word_t),
  parameter int NREG   = NREG_DEFAULT,
  parameter int PEND_W = 2,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NREAD*AW-1:0]      ra_i,
  output logic [NREAD*DATA_W-1:0]  rd_o,
  output logic [NREAD-1:0]         rd_ready_o,
  input  logic [NWRITE-1:0]        we_i,
  input  logic [NWRITE*AW-1:0]     wa_i,
  input  logic [NWRITE*DATA_W-1:0] wd_i,
  input  logic [NWRITE-1:0]        wb_release_i,
  input  logic                     iss_valid_i,
  input  logic [AW-1:0]            iss_addr_i,
  output logic                     iss_stall_o,
  input  logic                     flush_i,
  output logic                     err_underflow_o
);
  logic [DATA_W-1:0] regs_q  [NREG];
  logic              wr_hit  [NREG];
  logic [DATA_W-1:0] wr_data [NREG];
  logic [AW-1:0]     wa_a    [NWRITE];
  logic [DATA_W-1:0] wd_a    [NWRITE];

  for (genvar gi = 0; gi < NWRITE; gi++) begin : g_port
    assign wa_a[gi] = wa_i[gi*AW +: AW];
    assign wd_a[gi] = wd_i[gi*DATA_W +: DATA_W];
  end

  // Ports scanned low to high so the highest-index writer to an address wins.
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      wr_hit[k]  = 1'b0;
      wr_data[k] = '0;
      for (int i = 0; i < NWRITE; i++) begin
        if (k != 0 && we_i[i] && (wa_a[i] == AW'(k))) begin
          wr_hit[k]  = 1'b1;
          wr_data[k] = wd_a[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++)
        if (wr_hit[k]) regs_q[k] <= wr_data[k];
    end
  end

  for (genvar gj = 0; gj < NREAD; gj++) begin : g_read
    logic [AW-1:0] ra_j;
    assign ra_j = ra_i[gj*AW +: AW];
    assign rd_o[gj*DATA_W +: DATA_W] =
        (reset_i || ra_j == AW'(REG_ZERO)) ? '0 :
        wr_hit[ra_j]                       ? wr_data[ra_j] : regs_q[ra_j];
  end

  rf_scoreboard #(
    .NREAD (NREAD),
    .NWRITE(NWRITE),
    .NREG  (NREG),
    .PEND_W(PEND_W),
    .AW    (AW)
  ) u_sb (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .ra_i           (ra_i),
    .we_i           (we_i),
    .wa_i           (wa_i),
    .wb_release_i   (wb_release_i),
    .iss_valid_i    (iss_valid_i),
    .iss_addr_i     (iss_addr_i),
    .flush_i        (flush_i),
    .rd_ready_o     (rd_ready_o),
    .iss_stall_o    (iss_stall_o),
    .err_underflow_o(err_underflow_o)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios plus random traffic against an array-based model.
module tb_regfile_mp_sb;
  logic         clk = 1'b0;
  logic         rst;
  logic [19:0]  ra;
  logic [127:0] rd;
  logic [3:0]   rd_ready;
  logic [1:0]   we;
  logic [9:0]   wa;
  logic [63:0]  wd;
  logic [1:0]   wb_release;
  logic         iss_valid;
  logic [4:0]   iss_addr;
  logic         iss_stall;
  logic         flush;
  logic         err_uf;

  int n_cmp = 0;
  int n_bad = 0;
  bit run   = 0;

  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_uf;

  regfile_mp_sb dut (
    .clk_i(clk), .reset_i(rst), .ra_i(ra), .rd_o(rd), .rd_ready_o(rd_ready),
    .we_i(we), .wa_i(wa), .wd_i(wd), .wb_release_i(wb_release),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .iss_stall_o(iss_stall),
    .flush_i(flush), .err_underflow_o(err_uf)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wa_of(int i);
    return int'(wa[i*5 +: 5]);
  endfunction

  function automatic bit model_stall();
    return iss_valid && m_cnt[iss_addr] == 3;
  endfunction

  function automatic int model_next(int k, output bit uf);
    int t, dec;
    uf = 0;
    if (flush || k == 0) return 0;
    dec = 0;
    for (int i = 0; i < 2; i++)
      if (we[i] && wb_release[i] && wa_of(i) == k) dec++;
    t = m_cnt[k] + ((iss_valid && !model_stall() && int'(iss_addr) == k) ? 1 : 0) - dec;
    if (t < 0) begin uf = 1; t = 0; end
    return t;
  endfunction

  function automatic logic [31:0] model_rd(int a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_reg[a];
    for (int i = 0; i < 2; i++)
      if (we[i] && wa_of(i) == a) v = wd[i*32 +: 32];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin m_reg[k] = 0; m_cnt[k] = 0; end
    m_uf = 0;
  endtask

  task automatic model_update();
    int nxt [32];
    bit u, any;
    any = 0;
    for (int k = 0; k < 32; k++) begin
      nxt[k] = model_next(k, u);
      any |= u;
    end
    for (int i = 0; i < 2; i++)
      if (we[i] && wa_of(i) != 0) m_reg[wa_of(i)] = wd[i*32 +: 32];
    for (int k = 0; k < 32; k++) m_cnt[k] = nxt[k];
    if (any) m_uf = 1;
  endtask

  always @(negedge clk) begin
    if (run && !rst) begin
      bit u;
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("rd%0d", j), rd[j*32 +: 32], model_rd(int'(ra[j*5 +: 5])));
        chk($sformatf("rd_ready%0d", j), 32'(rd_ready[j]),
            32'(model_next(int'(ra[j*5 +: 5]), u) == 0));
      end
      chk("iss_stall", 32'(iss_stall), 32'(model_stall()));
      chk("err_underflow", 32'(err_uf), 32'(m_uf));
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  task automatic quiet();
    ra = '0; we = '0; wa = '0; wd = '0; wb_release = '0;
    iss_valid = 0; iss_addr = '0; flush = 0;
  endtask

  task automatic set_ra(int j, int a);
    ra[j*5 +: 5] = 5'(a);
  endtask

  task automatic wport(int i, bit rel, int a, logic [31:0] d);
    we[i] = 1'b1; wb_release[i] = rel; wa[i*5 +: 5] = 5'(a); wd[i*32 +: 32] = d;
  endtask

  task automatic iss(int a);
    iss_valid = 1'b1; iss_addr = 5'(a);
  endtask

  // Async reset asserted mid-cycle, released after one edge.
  task automatic do_reset();
    quiet();
    #1 rst = 1'b1;
    model_clear();
    #1;
    chk("reset_rd_all", rd[31:0] | rd[63:32] | rd[95:64] | rd[127:96], 32'h0);
    chk("reset_ready_all", 32'(rd_ready), 32'hF);
    chk("reset_uf", 32'(err_uf), 32'h0);
    cycle();
    rst = 1'b0;
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  task automatic random_cycles(int n);
    for (int c = 0; c < n; c++) begin
      quiet();
      for (int j = 0; j < 4; j++) set_ra(j, rnd_addr());
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 1) == 1) wport(i, $urandom_range(0, 9) < 6, rnd_addr(), $urandom);
      if ($urandom_range(0, 1) == 1) iss(rnd_addr());
      flush = ($urandom_range(0, 15) == 0);
      cycle();
    end
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    model_clear();
    #2;
    chk("por_rd0", rd[31:0], 32'h0);
    chk("por_ready", 32'(rd_ready), 32'hF);
    cycle();
    rst = 1'b0;
    run = 1'b1;

    // r5 write then async reset mid-cycle
    quiet(); wport(0, 0, 5, 32'hDEAD); cycle();
    quiet(); set_ra(0, 5); #1;
    chk("r5_before_reset", rd[31:0], 32'hDEAD);
    do_reset();

    // priority + bypass
    quiet(); set_ra(0, 7); wport(0, 0, 7, 32'hA); wport(1, 0, 7, 32'hB); #1;
    chk("prio_bypass", rd[31:0], 32'hB);
    cycle();
    quiet(); set_ra(0, 7); #1;
    chk("prio_stored", rd[31:0], 32'hB);
    cycle();

    // r0 write and issue
    quiet(); set_ra(0, 0); wport(0, 1, 0, 32'hFFFF_FFFF); iss(0); #1;
    chk("r0_rd", rd[31:0], 32'h0);
    chk("r0_ready", 32'(rd_ready[0]), 32'h1);
    chk("r0_stall", 32'(iss_stall), 32'h0);
    cycle();
    quiet(); set_ra(0, 0); #1;
    chk("r0_rd_after", rd[31:0], 32'h0);
    cycle();

    // saturation on r3
    for (int n = 0; n < 3; n++) begin
      quiet(); set_ra(0, 3); iss(3); #1;
      chk("sat_ready_issue", 32'(rd_ready[0]), 32'h0);
      chk("sat_no_stall", 32'(iss_stall), 32'h0);
      cycle();
    end
    quiet(); set_ra(0, 3); iss(3); #1;
    chk("sat_stall", 32'(iss_stall), 32'h1);
    cycle();
    for (int n = 0; n < 3; n++) begin
      quiet(); set_ra(0, 3); wport(0, 1, 3, 32'h33); #1;
      chk("sat_release_ready", 32'(rd_ready[0]), (n == 2) ? 32'h1 : 32'h0);
      cycle();
    end

    // r9 issue+release at cnt=1, then underflow
    quiet(); iss(9); cycle();
    quiet(); set_ra(0, 9); iss(9); wport(0, 1, 9, 32'h9); #1;
    chk("r9_iss_rel", 32'(rd_ready[0]), 32'h0);
    cycle();
    quiet(); set_ra(0, 9); wport(1, 1, 9, 32'h99); #1;
    chk("r9_last_rel", 32'(rd_ready[0]), 32'h1);
    cycle();
    quiet(); set_ra(0, 9); wport(0, 1, 9, 32'h999); #1;
    chk("r9_uf_pre", 32'(err_uf), 32'h0);
    cycle();
    quiet(); #1;
    chk("r9_uf_set", 32'(err_uf), 32'h1);
    cycle(); cycle();
    chk("r9_uf_sticky", 32'(err_uf), 32'h1);

    // flush with cnt(r4)=2 plus same-cycle issue and a data write
    quiet(); iss(4); cycle();
    quiet(); iss(4); cycle();
    quiet(); set_ra(0, 4); #1;
    chk("flush_pre_ready", 32'(rd_ready[0]), 32'h0);
    set_ra(1, 10); iss(4); flush = 1'b1; wport(1, 0, 10, 32'h1234); #1;
    chk("flush_ready", 32'(rd_ready[0]), 32'h1);
    chk("flush_bypass", rd[63:32], 32'h1234);
    cycle();
    quiet(); set_ra(0, 4); set_ra(1, 10); #1;
    chk("flush_after_ready", 32'(rd_ready[0]), 32'h1);
    chk("flush_write_kept", rd[63:32], 32'h1234);
    cycle();

    do_reset();
    random_cycles(400);
    do_reset();
    random_cycles(300);

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
